// File: rtl/jt12_wrbuf_pkg.sv
// jt12_wrbuf_pkg: shared types and constants for the jt12 host write buffer
package jt12_wrbuf_pkg;
  localparam int ENTRY_W = 10;
  typedef enum logic [1:0] {IDLE, STROBE, GAP, WAIT_BUSY} state_t;
endpackage

// File: rtl/jt12_wrbuf_fifo.sv
// jt12_wrbuf_fifo: single-clock FIFO with occupancy count, full and empty flags
module jt12_wrbuf_fifo
  import jt12_wrbuf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] dout,
  output logic [AW:0]        level,
  output logic               full,
  output logic               empty
);
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = level == (AW+1)'(DEPTH);
  assign empty   = level == '0;
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      level  <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/jt12_wrbuf.sv
// jt12_wrbuf: queues host writes and replays them to jt12_mmr as clean strobes, waiting out busy after data writes
module jt12_wrbuf
  import jt12_wrbuf_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_wr,
  input  logic [1:0]  host_addr,
  input  logic [7:0]  host_din,
  output logic        host_full,
  output logic        host_empty,
  output logic [AW:0] host_level,
  output logic        host_ovf,
  output logic        host_tmo,
  input  logic        err_clr,
  output logic        mmr_write,
  output logic [1:0]  mmr_addr,
  output logic [7:0]  mmr_din,
  input  logic        mmr_busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [ENTRY_W-1:0] head;
  logic fifo_empty, pop, tmo_set;
  jt12_wrbuf_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (host_wr),
    .pop   (pop),
    .din   ({host_addr, host_din}),
    .dout  (head),
    .level (host_level),
    .full  (host_full),
    .empty (fifo_empty)
  );
  assign host_empty = fifo_empty && state == IDLE;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pop     = 1'b0;
    tmo_set = 1'b0;
    case (state)
      IDLE: if (!fifo_empty && !mmr_busy) begin
        pop     = 1'b1;
        state_n = STROBE;
      end
      STROBE: state_n = GAP;
      GAP: begin
        state_n = mmr_addr[0] ? WAIT_BUSY : IDLE;
        cnt_n   = '0;
      end
      WAIT_BUSY: if (!mmr_busy) state_n = IDLE;
        else if (cnt == CW'(TIMEOUT - 1)) begin
          tmo_set = 1'b1;
          state_n = IDLE;
        end else cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  // the FIFO discards pushes at full, so host_full here flags exactly the dropped writes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mmr_write <= 1'b0;
      mmr_addr  <= '0;
      mmr_din   <= '0;
      host_ovf  <= 1'b0;
      host_tmo  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mmr_write <= pop;
      if (pop) {mmr_addr, mmr_din} <= head;
      host_ovf  <= err_clr ? 1'b0 : host_ovf | (host_wr & host_full);
      host_tmo  <= err_clr ? 1'b0 : host_tmo | tmo_set;
    end
endmodule

// File: tb/tb_jt12_wrbuf.sv
// tb_jt12_wrbuf: randomized bench comparing jt12_wrbuf against a timing-rule model of the write buffer
module tb_jt12_wrbuf;
  localparam int DEPTH = 16, AW = 4, TIMEOUT = 256;
  logic clk = 0, rst_n = 0, host_wr = 0, err_clr = 0, mmr_busy = 0;
  logic [1:0] host_addr = 0;
  logic [7:0] host_din = 0;
  logic host_full, host_empty, host_ovf, host_tmo, mmr_write;
  logic [AW:0] host_level;
  logic [1:0] mmr_addr;
  logic [7:0] mmr_din;
  jt12_wrbuf #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .host_wr(host_wr), .host_addr(host_addr), .host_din(host_din),
    .host_full(host_full), .host_empty(host_empty), .host_level(host_level),
    .host_ovf(host_ovf), .host_tmo(host_tmo), .err_clr(err_clr),
    .mmr_write(mmr_write), .mmr_addr(mmr_addr), .mmr_din(mmr_din), .mmr_busy(mmr_busy)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // model: the queue holds entries; timing expressed as the earliest edge a strobe may issue
  logic [9:0] q[$];
  logic [9:0] h;
  int e, ready_e, wstart;
  bit waiting, m_write, m_ovf, m_tmo, full_pre, tset, oset;
  logic [1:0] m_addr;
  logic [7:0] m_din;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      e = 0; ready_e = 0; waiting = 0;
      m_write = 0; m_addr = 0; m_din = 0; m_ovf = 0; m_tmo = 0;
    end else begin
      e++;
      full_pre = q.size() == DEPTH;
      tset = 0;
      m_write = 0;
      if (waiting) begin
        if (e >= wstart) begin
          if (!mmr_busy) begin waiting = 0; ready_e = e + 1; end
          else if (e == wstart + TIMEOUT - 1) begin waiting = 0; ready_e = e + 1; tset = 1; end
        end
      end else if (e >= ready_e && q.size() > 0 && !mmr_busy) begin
        h = q.pop_front();
        m_write = 1;
        {m_addr, m_din} = h;
        if (h[8]) begin waiting = 1; wstart = e + 3; end
        else ready_e = e + 3;
      end
      oset = host_wr && full_pre;
      if (host_wr && !full_pre) q.push_back({host_addr, host_din});
      m_ovf = err_clr ? 1'b0 : (m_ovf | oset);
      m_tmo = err_clr ? 1'b0 : (m_tmo | tset);
    end
  end
  int last_s = -100;
  always @(negedge clk) begin
    if (rst_n) begin
      check("mmr_write", mmr_write, m_write);
      check("mmr_addr", mmr_addr, m_addr);
      check("mmr_din", mmr_din, m_din);
      check("host_level", host_level, q.size());
      check("host_full", host_full, q.size() == DEPTH);
      check("host_empty", host_empty, q.size() == 0 && !(waiting || e < ready_e - 1));
      check("host_ovf", host_ovf, m_ovf);
      check("host_tmo", host_tmo, m_tmo);
      if (mmr_write) begin
        check("strobe_spacing", (e - last_s) >= 3, 1);
        last_s = e;
      end
    end else last_s = -100;
  end
  // register-map busy emulation: busy for busy_len clks after each data strobe
  int busy_cnt = 0, busy_len = 0;
  bit busy_force = 0;
  always @(negedge clk) begin
    if (!rst_n) busy_cnt = 0;
    else if (mmr_write && mmr_addr[0]) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    mmr_busy = busy_force || busy_cnt > 0;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    host_wr = 1; host_addr = a; host_din = d;
    tick(1);
    host_wr = 0;
  endtask
  task automatic wait_idle(input int max);
    int n = 0;
    while (!host_empty && n < max) begin tick(1); n++; end
    check("idle_reached", host_empty, 1);
  endtask
  task automatic wait_strobe(output int n, input int max);
    n = 0;
    while (!mmr_write && n < max) begin tick(1); n++; end
    check("strobe_seen", mmr_write, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    tick(1);
    check("rst_write", mmr_write, 0);
    check("rst_addr", mmr_addr, 0);
    check("rst_din", mmr_din, 0);
    check("rst_level", host_level, 0);
    check("rst_full", host_full, 0);
    check("rst_empty", host_empty, 1);
    check("rst_ovf", host_ovf, 0);
    check("rst_tmo", host_tmo, 0);
    wr(2'd0, 8'h28);
    check("t1_level", host_level, 1);
    check("t1_empty", host_empty, 0);
    tick(1);
    check("t1_write", mmr_write, 1);
    check("t1_addr", mmr_addr, 0);
    check("t1_din", mmr_din, 8'h28);
    tick(1);
    check("t1_write_low", mmr_write, 0);
    tick(1);
    check("t1_empty_back", host_empty, 1);
    busy_len = 40;
    wr(2'd0, 8'hA4);
    wr(2'd1, 8'h22);
    wr(2'd0, 8'h55);
    wait_strobe(n, 20);
    check("pair_addr", mmr_addr, 1);
    check("pair_din", mmr_din, 8'h22);
    tick(1);
    wait_strobe(n, 100);
    check("busy_gap", n + 1, 42);
    check("after_busy_din", mmr_din, 8'h55);
    wait_idle(100);
    check("pair_tmo", host_tmo, 0);
    busy_force = 1;
    tick(1);
    for (int i = 0; i < 17; i++) begin
      wr(2'($urandom_range(0, 3)), 8'($urandom));
      if (i == 15) begin
        check("ovf_level16", host_level, 16);
        check("ovf_full", host_full, 1);
        check("ovf_not_yet", host_ovf, 0);
      end
    end
    check("ovf_set", host_ovf, 1);
    check("ovf_level_kept", host_level, 16);
    err_clr = 1;
    tick(1);
    err_clr = 0;
    check("ovf_cleared", host_ovf, 0);
    busy_len = $urandom_range(0, 8);
    busy_force = 0;
    wait_idle(2000);
    busy_len = 300;
    wr(2'd1, 8'h11);
    wr(2'd0, 8'h33);
    check("tmo_strobe", mmr_write, 1);
    tick(1);
    wait_strobe(n, 400);
    check("tmo_gap", n + 1, 301);
    check("tmo_din", mmr_din, 8'h33);
    check("tmo_flag", host_tmo, 1);
    err_clr = 1;
    tick(1);
    err_clr = 0;
    check("tmo_cleared", host_tmo, 0);
    wait_idle(400);
    for (int i = 0; i < 600; i++) begin
      host_wr = $urandom_range(0, 2) == 0;
      host_addr = 2'($urandom_range(0, 3));
      host_din = 8'($urandom);
      err_clr = $urandom_range(0, 40) == 0;
      busy_len = $urandom_range(0, 12);
      tick(1);
    end
    host_wr = 0;
    err_clr = 0;
    wait_idle(3000);
    busy_len = 100;
    wr(2'd1, 8'h77);
    for (int i = 0; i < 5; i++) wr(2'($urandom_range(0, 3)), 8'($urandom));
    tick(10);
    check("rw_level5", host_level, 5);
    check("rw_waiting", host_empty, 0);
    rst_n = 0;
    #1;
    check("rw_write_now", mmr_write, 0);
    check("rw_level_now", host_level, 0);
    tick(2);
    rst_n = 1;
    tick(20);
    check("rw_level_after", host_level, 0);
    check("rw_empty_after", host_empty, 1);
    check("rw_no_strobe", mmr_write, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
